apb_busmux_n: RTL and testbench
===============================

Name: apb_busmux_n

Overview:
- Parametrised N-port APB decoder/mux that replaces the fixed 8-slave mux.
- One APB requester port fans out to NSLV completer ports, selected by a base/mask address map.
- Adds a registered transfer tracker, a per-transfer timeout watchdog, and a protocol-violation guard.
- Unmapped addresses go to an internal null device with a configurable error response.
- Sits between the AXI/AHB-to-APB bridge and the peripheral cluster (UART, timers, GPIO, PLIC shim).

Parameters:
- DWID, 32, data bus width.
- AWID, 32, address bus width.
- NSLV, 8, number of completer ports, 1..16.
- SLV_BASE, {NSLV{AWID'h0}}, flattened base addresses; port i occupies bits [i*AWID +: AWID].
- SLV_MASK, {NSLV{AWID'hFFFFF000}}, flattened decode masks; port i hits when (paddr & mask_i) == (base_i & mask_i).
- NULL_ERR, 0, pslverr value returned by the null device.
- TO_WID, 8, timeout counter width.
- TIMEOUT, 255, ACCESS cycles allowed before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- slv_psel  in  1  requester select
- slv_penable  in  1  requester enable
- slv_pwrite  in  1  requester write
- slv_paddr  in  AWID  requester address
- slv_pwdata  in  DWID  requester write data
- slv_pready  out  1  response ready to requester
- slv_pslverr  out  1  response error to requester
- slv_prdata  out  DWID  response read data to requester
- mst_psel  out  NSLV  per-port select, one-hot or zero
- mst_penable  out  NSLV  per-port enable
- mst_pwrite  out  1  shared write, gated by any select
- mst_paddr  out  AWID  shared address
- mst_pwdata  out  DWID  shared write data
- mst_pready  in  NSLV  per-port ready
- mst_pslverr  in  NSLV  per-port error
- mst_prdata  in  NSLV*DWID  flattened per-port read data
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by the watchdog
- err_addr_o  out  AWID  address of the last timed-out or errored transfer

Behaviour:
- Decode:
  - Lowest index wins on overlapping windows.
  - No hit selects the null device (index NSLV).
- State machine, states IDLE and ACCESS:
  - IDLE -> ACCESS when slv_psel & !slv_penable (SETUP). At that edge the decoded index goes into sel_q and slv_paddr into addr_q.
  - ACCESS -> IDLE when slv_pready is 1 (normal completion, null completion or timeout).
- SETUP cycle (IDLE, psel=1): mst_psel[dec] = 1 combinationally, mst_penable = 0.
- ACCESS cycle: mst_psel[sel_q] = 1 and mst_penable[sel_q] = slv_penable; the selection uses sel_q, not a re-decode of paddr.
- Response forwarding in ACCESS: slv_pready, slv_pslverr and slv_prdata are taken from port sel_q combinationally, with zero added latency.
- Null device: pready = 1 on the first ACCESS cycle, pslverr = NULL_ERR, prdata = 0.
- Watchdog:
  - The counter clears on SETUP and increments each ACCESS cycle that lacks pready.
  - When count == TIMEOUT-1 with no pready, the next cycle returns slv_pready = 1, slv_pslverr = 1, slv_prdata = 0 and pulses timeout_o.
  - In that abort cycle mst_psel and mst_penable are forced to 0; the machine returns to IDLE.
- Protocol guard: slv_penable = 1 while in IDLE gives an immediate slv_pready = 1, slv_pslverr = 1; no mst_psel is asserted.
- err_addr_o loads addr_q on any completion with slv_pslverr = 1.
- Idle outputs: mst_psel and mst_penable are 0; slv_pready, slv_pslverr and slv_prdata are 0.
- Requester drops psel mid-ACCESS: return to IDLE with no response; the completer sees psel fall.
- Back-to-back: a SETUP in the cycle after completion is accepted; there are no bubbles.
- Reset, asynchronous:
  - State = IDLE, sel_q = 0, addr_q = 0, counter = 0.
  - timeout_o = 0, err_addr_o = 0.
  - All outputs return to their idle values immediately, including mid-transfer.
- Widths: slv_prdata = mst_prdata[sel_q*DWID +: DWID]; sel_q is $clog2(NSLV+1) bits wide.

Decomposition:
- Package apb_pkg: state encoding (ST_IDLE, ST_ACCESS) and the null-response constants.
- Sub-module apb_addr_decoder: combinational priority base/mask decoder with parameters NSLV, AWID, SLV_BASE and SLV_MASK. Outputs are a one-hot hit vector plus an encoded index, where index NSLV means null.

Test Plan:
- NSLV=4, base 0x0/0x1000/0x2000/0x8000, mask 0xFFFFF000. Read 0x1004, port1 pready on the 2nd ACCESS cycle with prdata 0xA5A5A5A5 -> slv_prdata = 0xA5A5A5A5, pslverr = 0, mst_psel = 4'b0010 for 3 cycles.
- Write 0x9000, which is unmapped, with NULL_ERR=1 -> mst_psel = 0, slv_pready = 1 on the first ACCESS cycle, pslverr = 1, err_addr_o = 0x9000.
- TIMEOUT=4, port2 never ready -> after 4 ACCESS cycles: slv_pready = 1, pslverr = 1, timeout_o pulses once, mst_psel[2] drops.
- penable = 1 with no preceding SETUP -> pready = 1 and pslverr = 1 in the same cycle, all mst_psel = 0.
- Assert rstn = 0 mid-ACCESS to port3 -> all mst_psel and mst_penable = 0 asynchronously; the next transfer to 0x0 selects port0 correctly.
- Overlapping windows, port0 mask 0xFFFF0000 covering 0x1000 -> access to 0x1000 selects port0, not port1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared encodings for the parametrised APB decoder/mux: FSM states and the
// fixed response values of the internal null device, watchdog abort and protocol guard.
package apb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam logic NULL_PREADY   = 1'b1;
    localparam logic ABORT_PSLVERR = 1'b1;
    localparam logic GUARD_PSLVERR = 1'b1;

endpackage

// File: rtl/apb_addr_decoder.sv
// Priority base/mask address decoder. The lowest-index matching window wins;
// no match yields an empty hit vector and idx == NSLV (the null device).
module apb_addr_decoder #(
    parameter int                    NSLV     = 8,
    parameter int                    AWID     = 32,
    parameter logic [NSLV*AWID-1:0]  SLV_BASE = '0,
    parameter logic [NSLV*AWID-1:0]  SLV_MASK = {NSLV{AWID'(32'hFFFFF000)}}
) (
    input  logic [AWID-1:0]              addr,
    output logic [NSLV-1:0]              hit,
    output logic [$clog2(NSLV+1)-1:0]    idx
);
    localparam int SW = $clog2(NSLV+1);

    // Scan from the top down so that a lower-index match overrides a higher one.
    always_comb begin
        hit = '0;
        idx = SW'(NSLV);
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AWID +: AWID]) ==
                (SLV_BASE[i*AWID +: AWID] & SLV_MASK[i*AWID +: AWID])) begin
                hit    = '0;
                hit[i] = 1'b1;
                idx    = SW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_busmux_n.sv
// N-port APB decoder/mux: one requester fanned out to NSLV completers, with a
// null device for unmapped space, a per-transfer watchdog and an IDLE-penable guard.
module apb_busmux_n
    import apb_pkg::*;
#(
    parameter int                    DWID     = 32,
    parameter int                    AWID     = 32,
    parameter int                    NSLV     = 8,
    parameter logic [NSLV*AWID-1:0]  SLV_BASE = '0,
    parameter logic [NSLV*AWID-1:0]  SLV_MASK = {NSLV{AWID'(32'hFFFFF000)}},
    parameter bit                    NULL_ERR = 1'b0,
    parameter int                    TO_WID   = 8,
    parameter int                    TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  slv_psel,
    input  logic                  slv_penable,
    input  logic                  slv_pwrite,
    input  logic [AWID-1:0]       slv_paddr,
    input  logic [DWID-1:0]       slv_pwdata,
    output logic                  slv_pready,
    output logic                  slv_pslverr,
    output logic [DWID-1:0]       slv_prdata,
    output logic [NSLV-1:0]       mst_psel,
    output logic [NSLV-1:0]       mst_penable,
    output logic                  mst_pwrite,
    output logic [AWID-1:0]       mst_paddr,
    output logic [DWID-1:0]       mst_pwdata,
    input  logic [NSLV-1:0]       mst_pready,
    input  logic [NSLV-1:0]       mst_pslverr,
    input  logic [NSLV*DWID-1:0]  mst_prdata,
    output logic                  timeout_o,
    output logic [AWID-1:0]       err_addr_o
);
    localparam int SW = $clog2(NSLV+1);
    localparam logic [TO_WID-1:0] TO_LAST = TO_WID'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e         state, state_nxt;
    logic [SW-1:0]      sel_q;
    logic [AWID-1:0]    addr_q;
    logic [TO_WID-1:0]  to_cnt;
    logic               abort_q;

    logic [NSLV-1:0]    dec_hit;
    logic [SW-1:0]      dec_idx;
    logic [NSLV-1:0]    sel_oh;
    logic               sel_rdy, sel_err;
    logic [DWID-1:0]    sel_rdata;
    logic               setup, wd_fire;

    apb_addr_decoder #(
        .NSLV     (NSLV),
        .AWID     (AWID),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (slv_paddr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Response source for the latched port; sel_q == NSLV falls through to the null device.
    always_comb begin
        sel_oh    = '0;
        sel_rdy   = NULL_PREADY;
        sel_err   = NULL_ERR;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_rdy   = mst_pready[i];
                sel_err   = mst_pslverr[i];
                sel_rdata = mst_prdata[i*DWID +: DWID];
            end
        end
    end

    // Outputs are gated by rstn so they fall to idle values the moment reset asserts.
    always_comb begin
        state_nxt   = state;
        mst_psel    = '0;
        mst_penable = '0;
        slv_pready  = 1'b0;
        slv_pslverr = 1'b0;
        slv_prdata  = '0;
        timeout_o   = 1'b0;
        setup       = 1'b0;
        wd_fire     = 1'b0;
        if (rstn) begin
            case (state)
                ST_IDLE: begin
                    if (slv_penable) begin
                        slv_pready  = 1'b1;
                        slv_pslverr = GUARD_PSLVERR;
                    end else if (slv_psel) begin
                        setup     = 1'b1;
                        mst_psel  = dec_hit;
                        state_nxt = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!slv_psel) begin
                        state_nxt = ST_IDLE;
                    end else if (abort_q) begin
                        slv_pready  = 1'b1;
                        slv_pslverr = ABORT_PSLVERR;
                        timeout_o   = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        mst_psel    = sel_oh;
                        mst_penable = sel_oh & {NSLV{slv_penable}};
                        slv_pready  = sel_rdy;
                        slv_pslverr = sel_err;
                        slv_prdata  = sel_rdata;
                        if (sel_rdy) state_nxt = ST_IDLE;
                        else         wd_fire   = (TIMEOUT != 0) && (to_cnt == TO_LAST);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign mst_pwrite = slv_pwrite & (|mst_psel);
    assign mst_paddr  = slv_paddr;
    assign mst_pwdata = slv_pwdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            to_cnt     <= '0;
            abort_q    <= 1'b0;
            err_addr_o <= '0;
        end else begin
            state   <= state_nxt;
            abort_q <= wd_fire;
            if (setup) begin
                sel_q  <= dec_idx;
                addr_q <= slv_paddr;
                to_cnt <= '0;
            end else if (state == ST_ACCESS && !slv_pready) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (slv_pready && slv_pslverr) err_addr_o <= addr_q;
        end
    end

endmodule

// File: tb/tb_apb_busmux_n.sv
// Directed bench for apb_busmux_n: five modelled completers, responses checked by a
// scoreboard monitor decoupled from the stimulus; port4 is shadowed by port1 to test priority.
module tb_apb_busmux_n;
    localparam int NS = 5;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [NS*AW-1:0] BASE = {32'h0000_1800, 32'h0000_8000, 32'h0000_2000,
                                         32'h0000_1000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {32'hFFFF_F800, 32'hFFFF_F000, 32'hFFFF_F000,
                                         32'hFFFF_F000, 32'hFFFF_F000};
    localparam int          LAT [NS] = '{0, 1, 1000, 2, 0};
    localparam logic        ERR [NS] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] RD  [NS] = '{32'h1111_0000, 32'hA5A5_A5A5, 32'h2222_2222,
                                         32'h3333_3333, 32'h4444_4444};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic slv_psel = 1'b0, slv_penable = 1'b0, slv_pwrite = 1'b0;
    logic [AW-1:0] slv_paddr = '0;
    logic [DW-1:0] slv_pwdata = '0;
    logic slv_pready, slv_pslverr, timeout_o;
    logic [DW-1:0] slv_prdata;
    logic [NS-1:0] mst_psel, mst_penable, mst_pready, mst_pslverr;
    logic mst_pwrite;
    logic [AW-1:0] mst_paddr, err_addr_o;
    logic [DW-1:0] mst_pwdata;
    logic [NS*DW-1:0] mst_prdata;

    typedef struct { logic err; logic [31:0] rd; logic to; } rsp_t;
    rsp_t sb_q[$];
    int total = 0;
    int bad = 0;
    int acc_cnt [NS];

    always #5 clk = ~clk;

    apb_busmux_n #(
        .DWID(DW), .AWID(AW), .NSLV(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
        .NULL_ERR(1'b1), .TO_WID(8), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .slv_psel(slv_psel), .slv_penable(slv_penable), .slv_pwrite(slv_pwrite),
        .slv_paddr(slv_paddr), .slv_pwdata(slv_pwdata),
        .slv_pready(slv_pready), .slv_pslverr(slv_pslverr), .slv_prdata(slv_prdata),
        .mst_psel(mst_psel), .mst_penable(mst_penable), .mst_pwrite(mst_pwrite),
        .mst_paddr(mst_paddr), .mst_pwdata(mst_pwdata),
        .mst_pready(mst_pready), .mst_pslverr(mst_pslverr), .mst_prdata(mst_prdata),
        .timeout_o(timeout_o), .err_addr_o(err_addr_o)
    );

    // Completer models: ready after LAT[p] wait cycles in ACCESS.
    always @(posedge clk) begin
        for (int p = 0; p < NS; p++) begin
            if (mst_psel[p] && mst_penable[p] && !mst_pready[p]) acc_cnt[p] <= acc_cnt[p] + 1;
            else acc_cnt[p] <= 0;
        end
    end

    always_comb begin
        mst_pready  = '0;
        mst_pslverr = '0;
        mst_prdata  = '0;
        for (int p = 0; p < NS; p++) begin
            mst_pready[p]           = mst_psel[p] & mst_penable[p] & (acc_cnt[p] >= LAT[p]);
            mst_pslverr[p]          = ERR[p] & mst_pready[p];
            mst_prdata[p*DW +: DW]  = RD[p];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every requester-side completion pops one expected response.
    always @(negedge clk) begin
        if (rstn) begin
            if (slv_pready) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected: got pready=1 want no response");
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_pslverr", 32'(slv_pslverr), 32'(e.err));
                    chk("rsp_prdata", slv_prdata, e.rd);
                    chk("rsp_timeout", 32'(timeout_o), 32'(e.to));
                end
            end else if (timeout_o) begin
                total++; bad++;
                $display("FAIL spurious_timeout: got timeout_o=1 want 0");
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [NS-1:0] e_psel,
                        input int e_acc, input logic e_err, input logic [31:0] e_rd,
                        input logic e_to);
        int n;
        logic done;
        @(posedge clk); #1;
        slv_psel = 1'b1; slv_penable = 1'b0; slv_paddr = a; slv_pwrite = w;
        slv_pwdata = a ^ 32'hFFFF_0000;
        sb_q.push_back('{e_err, e_rd, e_to});
        @(negedge clk);
        chk("setup_psel", 32'(mst_psel), 32'(e_psel));
        chk("setup_penable", 32'(mst_penable), 32'h0);
        chk("setup_pwrite", 32'(mst_pwrite), 32'(w & (e_psel != 0)));
        chk("setup_pwdata", mst_pwdata, a ^ 32'hFFFF_0000);
        @(posedge clk); #1;
        slv_penable = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            done = slv_pready;
            chk("access_psel", 32'(mst_psel), (done && e_to) ? 32'h0 : 32'(e_psel));
            chk("access_penable", 32'(mst_penable), (done && e_to) ? 32'h0 : 32'(e_psel));
        end
        chk("access_cycles", n, e_acc);
    endtask

    task automatic idle_chk_err(input logic [31:0] e_addr);
        @(posedge clk); #1;
        slv_psel = 1'b0; slv_penable = 1'b0;
        chk("err_addr", err_addr_o, e_addr);
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_psel", 32'(mst_psel), 32'h0);
        chk("rst_pready", 32'(slv_pready), 32'h0);
        chk("rst_err_addr", err_addr_o, 32'h0);
        rstn = 1'b1;

        xfer(32'h1004, 1'b0, 5'b00010, 2, 1'b0, 32'hA5A5_A5A5, 1'b0);
        idle_chk_err(32'h0);
        xfer(32'h9000, 1'b1, 5'b00000, 1, 1'b1, 32'h0, 1'b0);
        idle_chk_err(32'h9000);
        xfer(32'h2000, 1'b0, 5'b00100, 5, 1'b1, 32'h0, 1'b1);
        idle_chk_err(32'h2000);

        // IDLE penable without SETUP: immediate error, no completer selected.
        @(posedge clk); #1;
        slv_psel = 1'b1; slv_penable = 1'b1; slv_paddr = 32'h1000;
        sb_q.push_back('{1'b1, 32'h0, 1'b0});
        @(negedge clk);
        chk("guard_pready", 32'(slv_pready), 32'h1);
        chk("guard_psel", 32'(mst_psel), 32'h0);
        idle_chk_err(32'h2000);

        // Back-to-back: priority window then port0 with no bubble.
        xfer(32'h1800, 1'b0, 5'b00010, 2, 1'b0, 32'hA5A5_A5A5, 1'b0);
        xfer(32'h0000, 1'b1, 5'b00001, 1, 1'b0, 32'h1111_0000, 1'b0);

        // Asynchronous reset in the middle of an ACCESS to port3.
        @(posedge clk); #1;
        slv_psel = 1'b1; slv_penable = 1'b0; slv_paddr = 32'h8000; slv_pwrite = 1'b0;
        @(negedge clk);
        chk("rstmid_setup_psel", 32'(mst_psel), 32'b01000);
        @(posedge clk); #1;
        slv_penable = 1'b1;
        @(negedge clk);
        chk("rstmid_access_pen", 32'(mst_penable), 32'b01000);
        #2 rstn = 1'b0;
        #1;
        chk("rstmid_psel", 32'(mst_psel), 32'h0);
        chk("rstmid_penable", 32'(mst_penable), 32'h0);
        chk("rstmid_pready", 32'(slv_pready), 32'h0);
        chk("rstmid_err_addr", err_addr_o, 32'h0);
        slv_psel = 1'b0; slv_penable = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        xfer(32'h0000, 1'b0, 5'b00001, 1, 1'b0, 32'h1111_0000, 1'b0);
        xfer(32'h8010, 1'b1, 5'b01000, 3, 1'b1, 32'h3333_3333, 1'b0);
        idle_chk_err(32'h8010);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "bench time limit");
    end

endmodule
